// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store unit between the
// execute stage and a valid/ready memory port. Builds word-aligned requests
// with byte enables and lane-replicated store data, aligns and extends load
// data, and pulses done/wb_valid for one cycle when an op completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// H/W accesses complete immediately with misalign=1 and never reach memory.
// XLEN is fixed at 32 by the RV32I lane arithmetic below.
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            is_store_q, is_store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      offs_q, offs_d;
    logic [4:0]      rd_q, rd_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            misalign_q, misalign_d;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic            trap;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    // Store lane decode from the incoming request; funct3[2] plays no part.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = req_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment check at accept: halfwords need addr[0]=0, words addr[1:0]=0.
    always_comb begin
        trap = 1'b0;
        case (req_funct3[1:0])
            2'b00:   trap = 1'b0;
            2'b01:   trap = req_addr[0];
            default: trap = |req_addr[1:0];
        endcase
    end
`else
    // Misaligned low bits are simply dropped; every access goes to memory.
    assign trap = 1'b0;
`endif

    // Load alignment and sign/zero extension of the returned word.
    always_comb begin
        ld_byte = mem_rdata[{offs_q, 3'b000} +: 8];
        ld_half = mem_rdata[{offs_q[1], 4'b0000} +: 16];
        case (funct3_q[1:0])
            2'b00:   ld_data = {{(XLEN-8){~funct3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{(XLEN-16){~funct3_q[2] & ld_half[15]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state logic: accept, hold the request until mem_ready, wait for
    // read data on loads, then a single response cycle.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        offs_d      = offs_q;
        rd_d        = rd_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        misalign_d  = misalign_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    is_store_d  = req_is_store;
                    funct3_d    = req_funct3;
                    offs_d      = req_addr[1:0];
                    rd_d        = req_rd;
                    mem_we_d    = req_is_store;
                    mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                    mem_be_d    = req_is_store ? st_be : 4'b1111;
                    mem_wdata_d = req_is_store ? st_wdata : '0;
                    state_d     = trap ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    state_d = is_store_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wb_data_d = ld_data;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // The visible completion fields only change on entry to RESP.
        if (state_d == RESP && state_q != RESP) begin
            wb_rd_d    = (state_q == IDLE) ? req_rd : rd_q;
            misalign_d = (state_q == IDLE) ? trap : 1'b0;
        end
    end

    // State and datapath registers; reset abandons any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            offs_q      <= 2'b00;
            rd_q        <= 5'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= 5'd0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            offs_q      <= offs_d;
            rd_q        <= rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            misalign_q  <= misalign_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_valid = (state_q == REQ);
    assign done      = (state_q == RESP);
    assign wb_valid  = (state_q == RESP) & ~is_store_q & (|rd_q) & ~misalign_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed stimulus with a behavioural model of the
// load/store rules; a single negedge process compares every output cycle.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_rvalid;
    logic        done, wb_valid, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    load_store_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .done(done), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the operation currently in flight.
    bit          chk_en = 1'b0, op_active = 1'b0;
    bit          m_store, m_trap;
    logic [2:0]  m_f3;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [4:0]  m_rd;
    int          m_R, m_done_k, t0;
    // Values the completion outputs must hold between responses.
    logic [4:0]  last_rd;
    logic        last_mis;
    logic [31:0] last_data;
    bit          last_dv;
    // DUT observations used by the literal checks.
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;
    bit          obs_mv_seen;
    int          obs_done_k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nbytes_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    // Byte offset actually used: misaligned low bits round down to the size.
    function automatic int off_of(input logic [2:0] f3, input logic [31:0] a);
        int n, lo;
        n  = nbytes_of(f3);
        lo = int'(a[1:0]);
        return lo - (lo % n);
    endfunction

    function automatic logic [3:0] exp_be(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes_of(f3);
        if (!st) return 4'hF;
        return 4'(((1 << n) - 1) << off_of(f3, a));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes_of(f3);
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] v;
        int n;
        n = nbytes_of(f3);
        v = (64'(d) >> (8 * off_of(f3, a))) & ((64'd1 << (8 * n)) - 64'd1);
        if (!f3[2] && n < 4 && ((v >> (8 * n - 1)) & 64'd1) == 64'd1)
            v = v - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        int  k;
        bit  act, e_mv, e_done, e_wbv;
        if (chk_en) begin
            k      = cyc - t0;
            act    = op_active && k >= 1 && k <= m_done_k;
            e_mv   = act && !m_trap && k <= m_R + 1;
            e_done = act && k == m_done_k;
            e_wbv  = e_done && !m_store && m_rd != 5'd0 && !m_trap;
            if (mem_valid) begin
                obs_mv_seen = 1'b1;
                obs_addr = mem_addr; obs_be = mem_be; obs_we = mem_we; obs_wdata = mem_wdata;
            end
            if (done) obs_done_k = k;
            chk("req_ready", 32'(req_ready), 32'(!act));
            chk("mem_valid", 32'(mem_valid), 32'(e_mv));
            chk("done", 32'(done), 32'(e_done));
            chk("wb_valid", 32'(wb_valid), 32'(e_wbv));
            if (e_mv) begin
                chk("mem_addr", mem_addr, m_addr & 32'hFFFF_FFFC);
                chk("mem_we", 32'(mem_we), 32'(m_store));
                chk("mem_be", 32'(mem_be), 32'(exp_be(m_store, m_f3, m_addr)));
                if (m_store) chk("mem_wdata", mem_wdata, exp_wdata(m_f3, m_wdata));
            end
            if (e_done) begin
                chk("misalign", 32'(misalign), 32'(m_trap));
                chk("wb_rd", 32'(wb_rd), 32'(m_rd));
                last_rd  = m_rd;
                last_mis = m_trap;
                if (!m_store && !m_trap) begin
                    chk("wb_data", wb_data, exp_load(m_f3, m_addr, m_rdata));
                    last_data = exp_load(m_f3, m_addr, m_rdata);
                    last_dv   = 1'b1;
                end else begin
                    last_dv = 1'b0;
                end
            end else begin
                chk("wb_rd_hold", 32'(wb_rd), 32'(last_rd));
                chk("misalign_hold", 32'(misalign), 32'(last_mis));
                if (last_dv) chk("wb_data_hold", wb_data, last_data);
            end
        end
    end

    // One complete op: R cycles of mem_ready low, V cycles of mem_rvalid low.
    // hold keeps req_valid asserted with junk fields while busy; noise drives
    // mem_rvalid outside WAIT with wrong data.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int R, input int V, input bit hold, input bit noise);
        bit mis;
        mis = (int'(addr[1:0]) % nbytes_of(f3)) != 0;
        @(posedge clk); #1;
        m_store = st; m_f3 = f3; m_addr = addr; m_wdata = wdata; m_rd = rd; m_rdata = rdata;
        m_R = R; m_trap = TRAP_EN && mis;
        m_done_k = m_trap ? 1 : (st ? 2 + R : 3 + R + V);
        obs_done_k = -1; obs_mv_seen = 1'b0;
        t0 = cyc; op_active = 1'b1;
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        for (int k = 1; k <= m_done_k + 1; k++) begin
            @(posedge clk); #1;
            req_valid = hold && k <= m_done_k;
            req_is_store = !st; req_funct3 = 3'b010; req_addr = 32'hFFFF_FFF0 ^ 32'(k);
            req_wdata = 32'hFFFF_FFFF; req_rd = 5'd31;
            mem_ready = (k == R + 1);
            if (!st && k == R + 2 + V) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end else if (noise && (k <= R + 1 || k == m_done_k)) begin
                mem_rvalid = 1'b1; mem_rdata = ~rdata;
            end else begin
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
        end
        req_valid = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        t0 = 0; m_done_k = 0; m_R = 0; m_trap = 1'b0; m_store = 1'b0;
        m_f3 = 3'b000; m_addr = '0; m_wdata = '0; m_rdata = '0; m_rd = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        #2 rst_n = 1'b1;
        last_rd = '0; last_mis = 1'b0; last_data = '0; last_dv = 1'b1;
        chk_en = 1'b1;

        // SW, immediate ready.
        do_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0, 1'b0, 1'b1);
        chk("sw_addr", obs_addr, 32'h104);
        chk("sw_be", 32'(obs_be), 32'hF);
        chk("sw_we", 32'(obs_we), 32'd1);
        chk("sw_done_cycle", 32'(obs_done_k), 32'd2);
        // SB to the top byte lane.
        do_op(1'b1, 3'b000, 32'h203, 32'h000000A5, 5'd1, 32'h0, 0, 0, 1'b0, 1'b0);
        chk("sb_be", 32'(obs_be), 32'h8);
        chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);
        chk("sb_addr", obs_addr, 32'h200);
        // Byte store with funct3[2] set still behaves as SB.
        do_op(1'b1, 3'b100, 32'h201, 32'h00000077, 5'd1, 32'h0, 1, 0, 1'b0, 1'b0);
        chk("sbu_be", 32'(obs_be), 32'h2);
        // SH to the upper half.
        do_op(1'b1, 3'b001, 32'h106, 32'h1234ABCD, 5'd2, 32'h0, 2, 0, 1'b1, 1'b0);
        chk("sh_be", 32'(obs_be), 32'hC);
        chk("sh_wdata", obs_wdata, 32'hABCDABCD);
        // Byte/half loads from the same word.
        do_op(1'b0, 3'b000, 32'h302, 32'h0, 5'd5, 32'h12805634, 0, 0, 1'b0, 1'b0);
        chk("lb_data", wb_data, 32'hFFFFFF80);
        chk("lb_done_cycle", 32'(obs_done_k), 32'd3);
        do_op(1'b0, 3'b100, 32'h302, 32'h0, 5'd6, 32'h12805634, 0, 0, 1'b0, 1'b1);
        chk("lbu_data", wb_data, 32'h00000080);
        do_op(1'b0, 3'b101, 32'h302, 32'h0, 5'd7, 32'h12805634, 1, 1, 1'b0, 1'b0);
        chk("lhu_data", wb_data, 32'h00001280);
        chk("lhu_rd", 32'(wb_rd), 32'd7);
        do_op(1'b0, 3'b001, 32'h300, 32'h0, 5'd8, 32'h00008001, 0, 0, 1'b0, 1'b0);
        chk("lh_data", wb_data, 32'hFFFF8001);
        // LW with ready low 3 cycles and rvalid 2 cycles late, req_valid held.
        do_op(1'b0, 3'b010, 32'h108, 32'h0, 5'd9, 32'h89ABCDEF, 3, 2, 1'b1, 1'b1);
        chk("lw_slow_done_cycle", 32'(obs_done_k), 32'd8);
        chk("lw_slow_data", wb_data, 32'h89ABCDEF);
        // funct3=011 behaves as a word load.
        do_op(1'b0, 3'b011, 32'h10C, 32'h0, 5'd10, 32'h0F0F1234, 0, 1, 1'b0, 1'b0);
        chk("l011_data", wb_data, 32'h0F0F1234);
        // Load to x0 completes without a register write.
        do_op(1'b0, 3'b000, 32'h301, 32'h0, 5'd0, 32'h0000FF00, 0, 0, 1'b0, 1'b0);
        // Misaligned word load.
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd11, 32'hCAFEF00D, 0, 0, 1'b0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("trap_done_cycle", 32'(obs_done_k), 32'd1);
        chk("trap_no_mem", 32'(obs_mv_seen), 32'd0);
        chk("trap_misalign", 32'(misalign), 32'd1);
`else
        chk("lw_mis_addr", obs_addr, 32'h100);
        chk("lw_mis_flag", 32'(misalign), 32'd0);
        chk("lw_mis_data", wb_data, 32'hCAFEF00D);
`endif
        // Misaligned halfword store.
        do_op(1'b1, 3'b001, 32'h403, 32'h00005A5A, 5'd12, 32'h0, 0, 0, 1'b0, 1'b0);

        // Reset pulsed while a load waits for read data.
        chk_en = 1'b0; op_active = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h400; req_rd = 5'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        chk("wait_mem_valid", 32'(mem_valid), 32'd0);
        chk("wait_req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_be", 32'(mem_be), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_wb_valid", 32'(wb_valid), 32'd0);
            chk("post_rst_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk); #1;
        end
        last_rd = '0; last_mis = 1'b0; last_data = '0; last_dv = 1'b1;
        chk_en = 1'b1;
        // Unit is usable again after the abandoned op.
        do_op(1'b0, 3'b100, 32'h501, 32'h0, 5'd4, 32'h0000C300, 1, 0, 1'b0, 1'b0);
        chk("after_rst_data", wb_data, 32'h000000C3);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
